// File: rtl/branch_issue_sched.sv
// branch_issue_sched: age-ordered branch issue buffer feeding the single branch FU, with CLEAR/SQUASH handling
module branch_issue_sched #(
    parameter int DEPTH     = 4,
    parameter int B_TAGS    = 4,
    parameter int PAYLOAD_W = 128
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         alloc_valid,
    input  logic [B_TAGS-1:0]            alloc_b_id,
    input  logic [B_TAGS-1:0]            alloc_b_mask,
    input  logic [PAYLOAD_W-1:0]         alloc_payload,
    output logic                         alloc_ready,
    input  logic                         issue_stall,
    output logic                         issue_valid,
    output logic [B_TAGS-1:0]            issue_b_id,
    output logic [B_TAGS-1:0]            issue_b_mask,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    input  logic [1:0]                   resolve_task,
    input  logic [B_TAGS-1:0]            resolve_b_id,
    output logic [$clog2(DEPTH):0]       occupancy
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0]     r_valid;
    logic [B_TAGS-1:0]    r_b_id    [DEPTH];
    logic [B_TAGS-1:0]    r_b_mask  [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [DEPTH-1:0]     r_older   [DEPTH];
    logic                 r_iv;
    logic [B_TAGS-1:0]    r_ib_id;
    logic [B_TAGS-1:0]    r_ib_mask;
    logic [PAYLOAD_W-1:0] r_ipay;
    logic                 r_alloc_ready;
    logic [CW-1:0]        r_occ;

    logic                 w_squash;
    logic                 w_clear;
    logic                 w_kill_reg;
    logic                 w_sel_en;
    logic                 w_acc;
    logic                 w_any_sel;
    logic [B_TAGS-1:0]    w_clr_mask;
    logic [DEPTH-1:0]     w_cand;
    logic [DEPTH-1:0]     w_sel;
    logic [DEPTH-1:0]     w_next_valid;
    logic [IW-1:0]        w_sel_idx;
    logic [IW-1:0]        w_free_idx;
    logic [CW-1:0]        w_next_cnt;

    assign w_squash   = resolve_task == 2'd2;
    assign w_clear    = resolve_task == 2'd1;
    assign w_clr_mask = w_clear ? ~resolve_b_id : '1;
    assign w_kill_reg = w_squash && |(r_ib_mask & resolve_b_id);
    assign w_sel_en   = !r_iv || !issue_stall;
    assign w_acc      = alloc_valid && r_alloc_ready && !(w_squash && |(alloc_b_mask & resolve_b_id));

    // r_older[i][j] set means entry j was allocated before entry i
    always_comb begin
        w_cand     = '0;
        w_sel      = '0;
        w_sel_idx  = '0;
        w_any_sel  = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            w_cand[i] = r_valid[i] && !(w_squash && |(r_b_mask[i] & resolve_b_id));
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = w_cand[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && w_cand[j] && r_older[i][j]) w_sel[i] = 1'b0;
        end
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!r_valid[i]) w_free_idx = IW'(i);
        for (int i = 0; i < DEPTH; i++)
            if (w_sel[i]) begin
                w_sel_idx = IW'(i);
                w_any_sel = 1'b1;
            end
    end

    always_comb begin
        w_next_valid = '0;
        w_next_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_next_valid[i] = (w_cand[i] && !(w_sel_en && w_sel[i])) || (w_acc && w_free_idx == IW'(i));
            w_next_cnt      = w_next_cnt + CW'(w_next_valid[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid       <= '0;
            r_iv          <= 1'b0;
            r_ib_id       <= '0;
            r_ib_mask     <= '0;
            r_ipay        <= '0;
            r_alloc_ready <= 1'b1;
            r_occ         <= '0;
        end else begin
            r_valid       <= w_next_valid;
            r_occ         <= w_next_cnt;
            r_alloc_ready <= w_next_cnt != CW'(DEPTH);
            for (int i = 0; i < DEPTH; i++)
                r_b_mask[i] <= r_b_mask[i] & w_clr_mask;
            if (w_acc) begin
                r_b_id[w_free_idx]    <= alloc_b_id;
                r_b_mask[w_free_idx]  <= alloc_b_mask & w_clr_mask;
                r_payload[w_free_idx] <= alloc_payload;
                for (int j = 0; j < DEPTH; j++) begin
                    r_older[w_free_idx][j] <= 1'b1;
                    r_older[j][w_free_idx] <= 1'b0;
                end
            end
            if (w_sel_en && w_any_sel) begin
                r_iv      <= 1'b1;
                r_ib_id   <= r_b_id[w_sel_idx];
                r_ib_mask <= r_b_mask[w_sel_idx] & w_clr_mask;
                r_ipay    <= r_payload[w_sel_idx];
            end else begin
                r_iv      <= r_iv && issue_stall && !w_kill_reg;
                r_ib_mask <= r_ib_mask & w_clr_mask;
            end
        end
    end

    assign alloc_ready   = r_alloc_ready;
    assign occupancy     = r_occ;
    assign issue_valid   = r_iv && !issue_stall && !w_kill_reg;
    assign issue_b_id    = r_ib_id;
    assign issue_b_mask  = r_ib_mask;
    assign issue_payload = r_ipay;
endmodule

// File: tb/tb_branch_issue_sched.sv
// tb_branch_issue_sched: directed vectors for branch_issue_sched with hand-computed expectations
module tb_branch_issue_sched;
    logic         clock = 1'b0;
    logic         reset;
    logic         alloc_valid;
    logic [3:0]   alloc_b_id;
    logic [3:0]   alloc_b_mask;
    logic [127:0] alloc_payload;
    logic         alloc_ready;
    logic         issue_stall;
    logic         issue_valid;
    logic [3:0]   issue_b_id;
    logic [3:0]   issue_b_mask;
    logic [127:0] issue_payload;
    logic [1:0]   resolve_task;
    logic [3:0]   resolve_b_id;
    logic [2:0]   occupancy;

    int n_chk  = 0;
    int n_pass = 0;

    branch_issue_sched #(.DEPTH(4), .B_TAGS(4), .PAYLOAD_W(128)) dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_b_id    (alloc_b_id),
        .alloc_b_mask  (alloc_b_mask),
        .alloc_payload (alloc_payload),
        .alloc_ready   (alloc_ready),
        .issue_stall   (issue_stall),
        .issue_valid   (issue_valid),
        .issue_b_id    (issue_b_id),
        .issue_b_mask  (issue_b_mask),
        .issue_payload (issue_payload),
        .resolve_task  (resolve_task),
        .resolve_b_id  (resolve_b_id),
        .occupancy     (occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic half();
        @(negedge clock);
    endtask

    task automatic drive(input logic av, input logic [3:0] id, input logic [3:0] m, input logic [127:0] pay,
                         input logic st, input logic [1:0] rt, input logic [3:0] rid);
        alloc_valid   = av;
        alloc_b_id    = id;
        alloc_b_mask  = m;
        alloc_payload = pay;
        issue_stall   = st;
        resolve_task  = rt;
        resolve_b_id  = rid;
    endtask

    initial begin
        logic [3:0] ids [5];
        ids = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        reset = 1'b0;
        half();
        check("rst_iv", issue_valid, 0);
        check("rst_id", issue_b_id, 0);
        check("rst_mask", issue_b_mask, 0);
        check("rst_pay", issue_payload, 0);
        check("rst_occ", occupancy, 0);
        check("rst_rdy", alloc_ready, 1);

        cyc(); drive(1, 4'b0001, 4'b0000, 128'hA1, 0, 0, 0); half();
        cyc(); drive(0, 0, 0, 0, 0, 0, 0); half();
        check("basic_occ1", occupancy, 1);
        check("basic_iv_c1", issue_valid, 0);
        cyc(); half();
        check("basic_iv_c2", issue_valid, 1);
        check("basic_id", issue_b_id, 4'b0001);
        check("basic_pay", issue_payload, 128'hA1);
        check("basic_occ0", occupancy, 0);
        cyc(); half();
        check("basic_done", issue_valid, 0);

        cyc(); drive(1, 4'b0001, 0, 128'hA, 1, 0, 0); half();
        cyc(); drive(1, 4'b0010, 0, 128'hB, 1, 0, 0); half();
        cyc(); drive(1, 4'b0100, 0, 128'hC, 1, 0, 0); half();
        cyc(); drive(0, 0, 0, 0, 0, 0, 0); half();
        check("age_occ", occupancy, 2);
        check("age_iv", issue_valid, 1);
        check("age_a", issue_b_id, 4'b0001);
        cyc(); half();
        check("age_b", issue_b_id, 4'b0010);
        cyc(); half();
        check("age_c", issue_b_id, 4'b0100);
        cyc(); half();
        check("age_done_iv", issue_valid, 0);
        check("age_done_occ", occupancy, 0);

        for (int k = 0; k < 5; k++) begin
            cyc(); drive(1, ids[k], 0, 128'hB0 + 128'(k), 1, 0, 0); half();
        end
        cyc(); drive(1, 4'b0010, 0, 128'hF6, 1, 0, 0); half();
        check("full_rdy0", alloc_ready, 0);
        check("full_occ4", occupancy, 4);
        cyc(); drive(0, 0, 0, 0, 1, 0, 0); half();
        check("full_ignored", occupancy, 4);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0); half();
        check("full_p0", issue_payload, 128'hB0);
        check("full_p0_rdy", alloc_ready, 0);
        cyc(); half();
        check("full_p1", issue_payload, 128'hB1);
        check("full_rdy1", alloc_ready, 1);
        check("full_occ3", occupancy, 3);
        for (int k = 2; k < 5; k++) begin
            cyc(); half();
            check("full_order", issue_payload, 128'hB0 + 128'(k));
            check("full_order_iv", issue_valid, 1);
        end
        cyc(); half();
        check("full_empty_iv", issue_valid, 0);
        check("full_empty_occ", occupancy, 0);

        cyc(); drive(1, 4'b1000, 4'b0011, 128'hC0, 1, 0, 0); half();
        cyc(); drive(1, 4'b0100, 4'b0001, 128'hC1, 1, 0, 0); half();
        cyc(); drive(1, 4'b0010, 4'b0000, 128'hC2, 1, 0, 0); half();
        cyc(); drive(0, 0, 0, 0, 0, 2'd2, 4'b0001); half();
        check("sq_kill_iv", issue_valid, 0);
        check("sq_pre_occ", occupancy, 2);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0); half();
        check("sq_y_iv", issue_valid, 1);
        check("sq_y_id", issue_b_id, 4'b0010);
        check("sq_occ0", occupancy, 0);
        cyc(); half();
        check("sq_done", issue_valid, 0);

        cyc(); drive(1, 4'b1000, 4'b0000, 128'hD0, 1, 0, 0); half();
        cyc(); drive(1, 4'b0001, 4'b0110, 128'hD1, 1, 0, 0); half();
        cyc(); drive(0, 0, 0, 0, 1, 2'd1, 4'b0010); half();
        cyc(); drive(0, 0, 0, 0, 1, 2'd2, 4'b0010); half();
        check("clr_occ_pre", occupancy, 1);
        check("clr_stall_iv", issue_valid, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0); half();
        check("clr_survive", occupancy, 1);
        check("clr_w_id", issue_b_id, 4'b1000);
        cyc(); half();
        check("clr_e_iv", issue_valid, 1);
        check("clr_e_id", issue_b_id, 4'b0001);
        check("clr_e_mask", issue_b_mask, 4'b0100);
        cyc(); half();
        check("clr_done", issue_valid, 0);

        cyc(); drive(1, 4'b0001, 4'b0100, 128'hE0, 0, 2'd2, 4'b0100); half();
        check("ar_rdy", alloc_ready, 1);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0); half();
        check("ar_dropped", occupancy, 0);
        cyc(); drive(1, 4'b0001, 4'b0100, 128'hE1, 0, 2'd1, 4'b0100); half();
        check("ar_drop_noissue", issue_valid, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0); half();
        check("ar_accepted", occupancy, 1);
        cyc(); half();
        check("ar_iv", issue_valid, 1);
        check("ar_mask", issue_b_mask, 4'b0000);
        check("ar_pay", issue_payload, 128'hE1);
        cyc(); half();
        check("ar_done", issue_valid, 0);

        cyc(); drive(1, 4'b0010, 0, 128'hF0, 1, 0, 0); half();
        cyc(); drive(1, 4'b0100, 0, 128'hF1, 1, 0, 0); half();
        cyc(); reset = 1'b1; drive(1, 4'b1000, 0, 128'hF2, 1, 0, 0); half();
        cyc(); reset = 1'b0; drive(0, 0, 0, 0, 0, 0, 0); half();
        check("mrst_iv", issue_valid, 0);
        check("mrst_occ", occupancy, 0);
        check("mrst_rdy", alloc_ready, 1);
        check("mrst_id", issue_b_id, 0);
        cyc(); half();
        check("mrst_after", issue_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
